inst_mem: RTL and testbench

- Instruction memory responder: the far end of the fetch interface driven by the pc/ce fetch-address generator in the cpu.
- Returns one 32-bit instruction per enabled fetch, with 1-cycle registered latency.
- Includes a byte-serial loader port so a boot/debug agent can write program contents before or between runs.
- Fetch and load are mutually exclusive: fetches are suppressed while a load is active.

---
 rtl/inst_mem_pkg.sv | 13 +
 rtl/inst_mem_ld_byte_packer.sv | 53 +++++
 rtl/inst_mem.sv | 124 ++++++++++++
 tb/tb_inst_mem.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_pkg.sv
// Shared types and constants for the instruction memory and its byte loader.
package inst_mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_e;

    localparam int unsigned BYTES_PER_WORD   = 4;
    localparam int unsigned CNT_W            = $clog2(BYTES_PER_WORD);
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/inst_mem_ld_byte_packer.sv
// Assembles little-endian bytes into 32-bit words; the word is presented
// combinationally in the cycle its last byte (or a flush) arrives.
module ld_byte_packer
    import inst_mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        byte_stb_i,
    input  logic [7:0]  byte_i,
    input  logic        clear_i,
    input  logic        flush_i,
    output logic [31:0] word_o,
    output logic        word_valid_o,
    output logic        partial_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      data_q, data_d;
    logic [31:0]      asm_word;

    always_comb begin
        asm_word = data_q;
        if (byte_stb_i) begin
            asm_word[{cnt_q, 3'b000} +: 8] = byte_i;
        end
        // Unfilled upper bytes are already zero, so a flush pads for free.
        word_valid_o = (byte_stb_i && (cnt_q == CNT_W'(BYTES_PER_WORD - 1)))
                    || (flush_i && (byte_stb_i || (cnt_q != '0)));
        word_o    = asm_word;
        partial_o = (cnt_q != '0);

        cnt_d  = cnt_q;
        data_d = data_q;
        if (clear_i || word_valid_o) begin
            cnt_d  = '0;
            data_d = '0;
        end else if (byte_stb_i) begin
            cnt_d  = cnt_q + 1'b1;
            data_d = asm_word;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            data_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/inst_mem.sv
// Instruction memory with 1-cycle registered fetch and a byte-serial loader.
// Optional misaligned-fetch check enabled by defining INST_MEM_ALIGN_CHK_EN.
module inst_mem
    import inst_mem_pkg::*;
#(
    parameter int unsigned ADDR_W   = 10,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce,
    input  logic [31:0]       addr,
    output logic [31:0]       inst,
    output logic              inst_valid,
    input  logic              ld_start,
    input  logic              ld_stop,
    input  logic              ld_byte_valid,
    input  logic [7:0]        ld_byte,
    output logic              ld_ready,
    output logic              ld_busy,
    output logic [ADDR_W:0]   ld_words,
    output logic              misalign
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [31:0]       mem [DEPTH];
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic [31:0]       inst_q;
    logic              valid_q, mis_q;

    logic              byte_stb, flush, wr_en, partial;
    logic [31:0]       wr_word;
    logic              fetch_en, mis_d;
    logic [ADDR_W-1:0] rd_idx;

    assign ld_busy    = (state_q == LOAD);
    assign ld_ready   = (state_q == LOAD);
    assign ld_words   = words_q;
    assign inst       = inst_q;
    assign inst_valid = valid_q;
    assign misalign   = mis_q;
    assign rd_idx     = addr[ADDR_W+1:2];

    // A restart discards everything in flight, including a byte in the same cycle.
    assign byte_stb = ld_byte_valid && ld_ready && !ld_start;
    assign flush    = (state_q == LOAD) && ld_stop && !ld_start;

    ld_byte_packer u_packer (
        .clk          (clk),
        .reset_n      (reset_n),
        .byte_stb_i   (byte_stb),
        .byte_i       (ld_byte),
        .clear_i      (ld_start),
        .flush_i      (flush),
        .word_o       (wr_word),
        .word_valid_o (wr_en),
        .partial_o    (partial)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        words_d = words_q;
        if (ld_start) begin
            state_d = LOAD;
            ptr_d   = '0;
            words_d = '0;
        end else if (state_q == LOAD) begin
            if (wr_en) begin
                ptr_d   = ptr_q + 1'b1;
                words_d = words_q + 1'b1;
            end
            if (ld_stop || (wr_en && (ptr_q == '1))) begin
                state_d = IDLE;
            end
        end
    end

`ifdef INST_MEM_ALIGN_CHK_EN
    assign mis_d = (state_q == IDLE) && ce && (addr[1:0] != 2'b00);
    logic unused_addr;
    assign unused_addr = ^{addr[31:ADDR_W+2], partial};
`else
    assign mis_d = 1'b0;
    logic unused_addr;
    assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0], partial};
`endif

    assign fetch_en = (state_q == IDLE) && ce && !mis_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            words_q <= words_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ptr_q] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            inst_q  <= fetch_en ? mem[rd_idx] : NOP_INST;
            valid_q <= fetch_en;
            mis_q   <= mis_d;
        end
    end

endmodule

// File: tb/tb_inst_mem.sv
// Scoreboard bench for inst_mem (ADDR_W=2 so the full/wrap cases are short).
module tb_inst_mem;
    import inst_mem_pkg::*;

    localparam int unsigned AW = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          ce = 1'b0;
    logic [31:0]   addr = '0;
    logic          ld_start = 1'b0;
    logic          ld_stop = 1'b0;
    logic          ld_byte_valid = 1'b0;
    logic [7:0]    ld_byte = '0;
    logic [31:0]   inst;
    logic          inst_valid;
    logic          ld_ready;
    logic          ld_busy;
    logic [AW:0]   ld_words;
    logic          misalign;

    inst_mem #(.ADDR_W(AW), .NOP_INST(32'h0000_0000)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ce            (ce),
        .addr          (addr),
        .inst          (inst),
        .inst_valid    (inst_valid),
        .ld_start      (ld_start),
        .ld_stop       (ld_stop),
        .ld_byte_valid (ld_byte_valid),
        .ld_byte       (ld_byte),
        .ld_ready      (ld_ready),
        .ld_busy       (ld_busy),
        .ld_words      (ld_words),
        .misalign      (misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       name;
        logic [31:0] inst;
        logic        v;
        logic        mis;
        logic        busy;
        logic [AW:0] words;
    } exp_t;

    exp_t q[$];
    int   cyc_now = 0;
    int   vectors = 0;
    int   miscompares = 0;

    // Monitor: one posedge per cycle, checks whatever the stimulus queued for it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc_now++;
            while (q.size() > 0 && q[0].cyc <= cyc_now) begin
                e = q.pop_front();
                vectors++;
                if (e.cyc != cyc_now ||
                    {inst, inst_valid, misalign, ld_busy, ld_ready, ld_words} !==
                    {e.inst, e.v, e.mis, e.busy, e.busy, e.words}) begin
                    miscompares++;
                    $display("FAIL %s @cyc %0d: got inst=%h v=%b mis=%b busy=%b rdy=%b words=%0d, want inst=%h v=%b mis=%b busy=%b rdy=%b words=%0d",
                             e.name, cyc_now, inst, inst_valid, misalign, ld_busy, ld_ready, ld_words,
                             e.inst, e.v, e.mis, e.busy, e.busy, e.words);
                end
            end
        end
    end

    task automatic drv(input string nm, input logic c, input logic [31:0] a,
                       input logic st, input logic sp, input logic bv, input logic [7:0] b,
                       input logic [31:0] ei, input logic ev, input logic em,
                       input logic eb, input logic [AW:0] ew);
        exp_t e;
        ce = c; addr = a; ld_start = st; ld_stop = sp; ld_byte_valid = bv; ld_byte = b;
        e.cyc = cyc_now + 1; e.name = nm; e.inst = ei; e.v = ev; e.mis = em;
        e.busy = eb; e.words = ew;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic ld(input string nm, input logic st, input logic sp, input logic bv,
                      input logic [7:0] b, input logic eb, input logic [AW:0] ew);
        drv(nm, 1'b0, 32'h0, st, sp, bv, b, 32'h0, 1'b0, 1'b0, eb, ew);
    endtask

    task automatic fetch(input string nm, input logic c, input logic [31:0] a,
                         input logic [31:0] ei, input logic ev, input logic em,
                         input logic [AW:0] ew);
        drv(nm, c, a, 1'b0, 1'b0, 1'b0, 8'h00, ei, ev, em, 1'b0, ew);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d", q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bytes_a [8];
        bytes_a = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

        @(negedge clk);
        ld("reset_0", 0, 0, 0, 8'h00, 0, 0);
        ld("reset_1", 0, 0, 1, 8'h55, 0, 0);
        reset_n = 1'b1;

        // Reset in the middle of a load
        ld("mid_start", 1, 0, 0, 8'h00, 1, 0);
        ld("mid_b1",    0, 0, 1, 8'h11, 1, 0);
        ld("mid_b2",    0, 0, 1, 8'h22, 1, 0);
        reset_n = 1'b0;
        ld("mid_reset", 0, 0, 0, 8'h00, 0, 0);
        reset_n = 1'b1;

        // Two full words
        ld("two_start", 1, 0, 0, 8'h00, 1, 0);
        for (int i = 0; i < 8; i++) begin
            ld("two_byte", 0, 0, 1, bytes_a[i], 1, 3'((i + 1) / 4));
        end
        ld("two_stop", 0, 1, 0, 8'h00, 0, 2);
        fetch("two_fetch0", 1, 32'h0, 32'h12345678, 1, 0, 2);
        fetch("two_fetch4", 1, 32'h4, 32'hDEADBEEF, 1, 0, 2);
        fetch("ce_low",     0, 32'h4, 32'h0, 0, 0, 2);

        // Partial word, zero padded
        ld("part_start", 1, 0, 0, 8'h00, 1, 0);
        ld("part_aa",    0, 0, 1, 8'hAA, 1, 0);
        ld("part_bb",    0, 0, 1, 8'hBB, 1, 0);
        ld("part_stop",  0, 1, 0, 8'h00, 0, 1);
        fetch("part_fetch0", 1, 32'h0, 32'h0000BBAA, 1, 0, 1);
        fetch("part_fetch4", 1, 32'h4, 32'hDEADBEEF, 1, 0, 1);

        // ce held high throughout a load
        ld("ceload_start", 1, 0, 0, 8'h00, 1, 0);
        for (int i = 0; i < 4; i++) begin
            drv("ceload_byte", 1, 32'h0, 0, 0, 1, 8'(i + 1), 32'h0, 0, 0, 1, 3'((i + 1) / 4));
        end
        drv("ceload_stop", 1, 32'h0, 0, 1, 0, 8'h00, 32'h0, 0, 0, 0, 1);
        fetch("ceload_fetch", 1, 32'h0, 32'h04030201, 1, 0, 1);

        // Stop in IDLE ignored; start+stop together starts; empty stop writes nothing
        ld("idle_stop",   0, 1, 0, 8'h00, 0, 1);
        ld("start_stop",  1, 1, 0, 8'h00, 1, 0);
        ld("empty_stop",  0, 1, 0, 8'h00, 0, 0);
        fetch("empty_fetch", 1, 32'h0, 32'h04030201, 1, 0, 0);

        // Fill the whole array, then one extra byte
        ld("full_start", 1, 0, 0, 8'h00, 1, 0);
        for (int i = 0; i < 16; i++) begin
            ld("full_byte", 0, 0, 1, 8'(8'h10 + i), (i < 15) ? 1'b1 : 1'b0, 3'((i + 1) / 4));
        end
        ld("full_extra", 0, 0, 1, 8'h20, 0, 4);
        fetch("wrap_fetch10", 1, 32'h10, 32'h13121110, 1, 0, 4);
        fetch("full_fetch1c", 1, 32'h1C, 32'h1F1E1D1C, 1, 0, 4);
`ifdef INST_MEM_ALIGN_CHK_EN
        fetch("misalign_2", 1, 32'h2, 32'h0, 0, 1, 4);
`else
        fetch("unaligned_2", 1, 32'h2, 32'h13121110, 1, 0, 4);
`endif
        fetch("after_mis", 0, 32'h0, 32'h0, 0, 0, 4);

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", q.size());
            miscompares += q.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
